// File: rtl/exec_pkg.sv
// Shared execute-stage types: result payload layout, unit indices and a
// small wrap-around index helper used by the arbiter and its pointer.
package exec_pkg;

  localparam int DATA_W   = 64;
  localparam int CMD_W    = 10;
  localparam int FLAG_W   = 4;
  localparam int ROB_SIZE = 16;
  localparam int TAG_W    = $clog2(ROB_SIZE + 1);

  localparam int UNIT_ALU = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_BR  = 2;
  localparam int UNIT_LS  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [FLAG_W-1:0] flags;
  } exec_result_t;

  // Descending index with wrap: 0 -> n-1.
  function automatic int prev_idx(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/exec_output_arbiter_if.sv
// Execute-unit request/payload bundle plus the valid/ready output toward memory.
interface exec_output_arbiter_if #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 10,
  parameter int FLAG_W     = 4,
  parameter int ROBsizeLog = 5
);

  logic [NUM_UNITS-1:0]  valid_i;
  logic [DATA_W-1:0]     executeVal_i      [NUM_UNITS];
  logic [CMD_W-1:0]      executeCommands_i [NUM_UNITS];
  logic [ROBsizeLog-1:0] executeTag_i      [NUM_UNITS];
  logic [FLAG_W-1:0]     executeFlags_i    [NUM_UNITS];
  logic [NUM_UNITS-1:0]  canGo_o;

  logic                  memReady_i;
  logic                  valid_o;
  logic [DATA_W-1:0]     dataToMem_o;
  logic [CMD_W-1:0]      commandsToMem_o;
  logic [ROBsizeLog-1:0] tagToMem_o;
  logic [FLAG_W-1:0]     flagsToMem_o;

  // Driven by the execution units and the memory stage.
  modport master (
    output valid_i, executeVal_i, executeCommands_i, executeTag_i, executeFlags_i,
    output memReady_i,
    input  canGo_o, valid_o, dataToMem_o, commandsToMem_o, tagToMem_o, flagsToMem_o
  );

  // The arbiter side.
  modport slave (
    input  valid_i, executeVal_i, executeCommands_i, executeTag_i, executeFlags_i,
    input  memReady_i,
    output canGo_o, valid_o, dataToMem_o, commandsToMem_o, tagToMem_o, flagsToMem_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational arbiter: searches ptr, ptr-1, ... with wrap and grants the
// first requester; grant is suppressed (but gnt_idx still valid) when en is low.
module rr_arbiter
  import exec_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
      idx = prev_idx(idx, N);
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/exec_output_arbiter.sv
// Execute-stage output arbiter: picks one finished unit per cycle and holds it
// in a single-entry output register that drains into memory on valid/ready.
module exec_output_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_W     = exec_pkg::DATA_W,
  parameter int CMD_W      = exec_pkg::CMD_W,
  parameter int FLAG_W     = exec_pkg::FLAG_W,
  parameter int ROBsize    = exec_pkg::ROB_SIZE,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RR_MODE    = 1
) (
  input logic                  clk_i,
  input logic                  reset_i,
  exec_output_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(NUM_UNITS - 1);

  logic                  ld;
  logic [NUM_UNITS-1:0]  gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      ptr_q;
  logic                  valid_q;
  logic [DATA_W-1:0]     val_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [ROBsizeLog-1:0] tag_q;
  logic [FLAG_W-1:0]     flags_q;

  // The register can take a new entry when empty or when memory drains it this edge.
  assign ld = !valid_q || bus.memReady_i;

  rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .req     (bus.valid_i),
    .ptr     (ptr_q),
    .en      (ld && !reset_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      val_q   <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      flags_q <= '0;
      ptr_q   <= PTR_TOP;
    end else if (ld) begin
      if (|gnt) begin
        valid_q <= 1'b1;
        val_q   <= bus.executeVal_i[gnt_idx];
        cmd_q   <= bus.executeCommands_i[gnt_idx];
        tag_q   <= bus.executeTag_i[gnt_idx];
        flags_q <= bus.executeFlags_i[gnt_idx];
        if (RR_MODE != 0) ptr_q <= IDX_W'(exec_pkg::prev_idx(int'(gnt_idx), NUM_UNITS));
      end else begin
        // Payload is left as-is; consumers qualify it with valid_o.
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.canGo_o         = gnt;
  assign bus.valid_o         = valid_q;
  assign bus.dataToMem_o     = val_q;
  assign bus.commandsToMem_o = cmd_q;
  assign bus.tagToMem_o      = tag_q;
  assign bus.flagsToMem_o    = flags_q;

endmodule

// File: tb/tb_exec_output_arbiter.sv
// Bench for exec_output_arbiter: a round-robin instance checked against a
// reference model and scoreboard, plus a fixed-priority instance on the same stimulus.
module tb_exec_output_arbiter;
  import exec_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_output_arbiter_if #(.NUM_UNITS(N), .DATA_W(DATA_W), .CMD_W(CMD_W),
                           .FLAG_W(FLAG_W), .ROBsizeLog(TAG_W)) bus_rr ();
  exec_output_arbiter_if #(.NUM_UNITS(N), .DATA_W(DATA_W), .CMD_W(CMD_W),
                           .FLAG_W(FLAG_W), .ROBsizeLog(TAG_W)) bus_fp ();

  exec_output_arbiter #(.NUM_UNITS(N), .RR_MODE(1)) dut_rr (
    .clk_i(clk), .reset_i(rst), .bus(bus_rr.slave));
  exec_output_arbiter #(.NUM_UNITS(N), .RR_MODE(0)) dut_fp (
    .clk_i(clk), .reset_i(rst), .bus(bus_fp.slave));

  int checks = 0;
  int errors = 0;

  exec_result_t cur_pl [N];
  int           gen    [N];
  exec_result_t exp_q  [$];
  exec_result_t last_pl;
  logic         m_valid;
  int           m_ptr;
  logic         chk_fp;

  function automatic exec_result_t mk(input int g, input int n);
    exec_result_t r;
    r.val   = {32'(g + 1), 32'(n * 7 + 1)};
    r.cmd   = CMD_W'(g * 64 + n);
    r.tag   = TAG_W'((g + 2 + n) % 17);
    r.flags = FLAG_W'(g ^ n);
    return r;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic mr);
    bus_rr.valid_i    = v;
    bus_fp.valid_i    = v;
    bus_rr.memReady_i = mr;
    bus_fp.memReady_i = mr;
    for (int g = 0; g < N; g++) begin
      bus_rr.executeVal_i[g]      = cur_pl[g].val;
      bus_rr.executeCommands_i[g] = cur_pl[g].cmd;
      bus_rr.executeTag_i[g]      = cur_pl[g].tag;
      bus_rr.executeFlags_i[g]    = cur_pl[g].flags;
      bus_fp.executeVal_i[g]      = cur_pl[g].val;
      bus_fp.executeCommands_i[g] = cur_pl[g].cmd;
      bus_fp.executeTag_i[g]      = cur_pl[g].tag;
      bus_fp.executeFlags_i[g]    = cur_pl[g].flags;
    end
  endtask

  // One cycle, entered just after a falling edge: drive, check grant, clock, check output.
  task automatic step(input logic [N-1:0] v, input logic mr, input logic r);
    logic [N-1:0]     exp_gnt;
    logic             ld;
    int               win;
    int               idx;
    exec_result_t     e;
    exec_result_t     obs;
    logic [TAG_W-1:0] fp_tag;
    rst = r;
    drive(v, mr);
    #1;
    ld      = !m_valid || mr;
    win     = -1;
    exp_gnt = '0;
    if (!r && ld) begin
      for (int k = 0; k < N; k++) begin
        idx = m_ptr - k;
        if (idx < 0) idx += N;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    checks++;
    if (bus_rr.canGo_o !== exp_gnt) begin
      errors++;
      $display("FAIL rr_canGo t=%0t got %b expected %b", $time, bus_rr.canGo_o, exp_gnt);
    end
    fp_tag = cur_pl[UNIT_LS].tag;
    if (chk_fp) begin
      checks++;
      if (bus_fp.canGo_o !== 4'b1000) begin
        errors++;
        $display("FAIL fp_canGo t=%0t got %b expected 1000", $time, bus_fp.canGo_o);
      end
    end
    if (r) begin
      m_valid = 1'b0;
      m_ptr   = N - 1;
      exp_q.delete();
      last_pl = '0;
    end else if (win >= 0) begin
      if (m_valid) last_pl = exp_q.pop_front();
      exp_q.push_back(cur_pl[win]);
      m_valid = 1'b1;
      m_ptr   = (win == 0) ? N - 1 : win - 1;
    end else if (ld) begin
      if (m_valid) last_pl = exp_q.pop_front();
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (win >= 0) begin
      gen[win]++;
      cur_pl[win] = mk(win, gen[win]);
    end
    e         = m_valid ? exp_q[0] : last_pl;
    obs.val   = bus_rr.dataToMem_o;
    obs.cmd   = bus_rr.commandsToMem_o;
    obs.tag   = bus_rr.tagToMem_o;
    obs.flags = bus_rr.flagsToMem_o;
    checks++;
    if (bus_rr.valid_o !== m_valid) begin
      errors++;
      $display("FAIL rr_valid_o t=%0t got %b expected %b", $time, bus_rr.valid_o, m_valid);
    end
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rr_payload t=%0t got %h expected %h", $time, obs, e);
    end
    if (chk_fp) begin
      checks++;
      if (bus_fp.valid_o !== 1'b1 || bus_fp.tagToMem_o !== fp_tag) begin
        errors++;
        $display("FAIL fp_output t=%0t got valid=%b tag=%0d expected valid=1 tag=%0d",
                 $time, bus_fp.valid_o, bus_fp.tagToMem_o, fp_tag);
      end
    end
  endtask

  task automatic test_reset();
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    checks++;
    if (bus_rr.tagToMem_o !== 5'd5) begin
      errors++;
      $display("FAIL reset_first_tag got %0d expected 5", bus_rr.tagToMem_o);
    end
  endtask

  task automatic test_rr_rotation();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
  endtask

  task automatic test_fixed_priority();
    chk_fp = 1'b1;
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);
    chk_fp = 1'b0;
  endtask

  task automatic test_stall();
    step(4'b0000, 1'b1, 1'b0);
    cur_pl[UNIT_ALU].val = 64'hDEAD;
    step(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 1'b0, 1'b0);
      checks++;
      if (bus_rr.dataToMem_o !== 64'hDEAD) begin
        errors++;
        $display("FAIL stall_hold got %h expected dead", bus_rr.dataToMem_o);
      end
    end
    step(4'b0011, 1'b1, 1'b0);
    checks++;
    if (bus_rr.tagToMem_o !== mk(UNIT_MUL, gen[UNIT_MUL] - 1).tag) begin
      errors++;
      $display("FAIL stall_release_unit got tag %0d expected unit %0d tag", bus_rr.tagToMem_o, UNIT_MUL);
    end
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_sparse();
    logic [CMD_W-1:0] held;
    step(4'b0001, 1'b1, 1'b0);
    held = exp_q[0].cmd;
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus_rr.commandsToMem_o !== held) begin
      errors++;
      $display("FAIL sparse_cmd_held got %h expected %h", bus_rr.commandsToMem_o, held);
    end
  endtask

  task automatic test_reset_stall();
    step(4'b0100, 1'b1, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++)
      step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'b0);
  endtask

  initial begin
    chk_fp  = 1'b0;
    m_valid = 1'b0;
    m_ptr   = N - 1;
    last_pl = '0;
    for (int g = 0; g < N; g++) begin
      gen[g]    = 0;
      cur_pl[g] = mk(g, 0);
    end
    drive('0, 1'b0);
    @(negedge clk);
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_stall();
    test_sparse();
    test_reset_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
